// File: rtl/gps_nco_update_sched_pkg.sv
// Shared types and helpers for the NCO update scheduler.
package gps_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam int PKG_WORD_W   = 30;
  localparam int PKG_CARR_LIM = 32'h0010_0000;

  // Clamp works on a wide signed container so any WORD_W up to 64 fits.
  localparam int CLAMP_W = 64;

  function automatic logic signed [CLAMP_W-1:0] clamp_s(
    input logic signed [CLAMP_W-1:0] v,
    input logic signed [CLAMP_W-1:0] lim
  );
    if (v > lim)       return lim;
    else if (v < -lim) return -lim;
    else               return v;
  endfunction

endpackage

// File: rtl/gps_nco_update_sched_if.sv
// Handshake between the scheduler and the shared loop-filter engine.
interface gps_nco_update_sched_if #(
  parameter int WORD_W = 30
) ();
  logic              lf_start;
  logic [2:0]        lf_ch;
  logic              lf_done;
  logic [WORD_W-1:0] lf_carr;
  logic [WORD_W-1:0] lf_code;

  modport master (output lf_start, lf_ch, input lf_done, lf_carr, lf_code);
  modport slave  (input lf_start, lf_ch, output lf_done, lf_carr, lf_code);
endinterface

// File: rtl/gps_nco_update_sched_rr_pick.sv
// Combinational round-robin picker: first set bit at or after i_rr_ptr, with wrap.
module gps_rr_pick #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] i_pending,
  input  logic [2:0]     i_rr_ptr,
  output logic           o_vld,
  output logic [2:0]     o_idx
);

  // Scan from the farthest candidate down so the nearest pending one wins.
  always_comb begin
    o_vld = 1'b0;
    o_idx = 3'd0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (i_pending[(int'(i_rr_ptr) + k) % NCH]) begin
        o_vld = 1'b1;
        o_idx = 3'((int'(i_rr_ptr) + k) % NCH);
      end
    end
  end

endmodule

// File: rtl/gps_nco_update_sched.sv
// Round-robin scheduler sharing one loop-filter engine among NCH tracking
// channels; holds the per-channel carrier/code NCO offset words.
module gps_nco_update_sched
  import gps_sched_pkg::*;
#(
  parameter int                NCH      = 4,
  parameter int                WORD_W   = PKG_WORD_W,
  parameter int                TIMEOUT  = 255,
  parameter logic [WORD_W-1:0] CARR_LIM = WORD_W'(PKG_CARR_LIM)
) (
  input  logic                    mclk,
  input  logic                    mclr,
  input  logic [NCH-1:0]          dump_req,
  input  logic [NCH-1:0]          ch_en,
  gps_nco_update_sched_if.master  lf,
  output logic [NCH*WORD_W-1:0]   carr_off,
  output logic [NCH*WORD_W-1:0]   code_off,
  output logic [NCH-1:0]          upd_pulse,
  output logic [NCH-1:0]          overrun,
  output logic                    timeout_err,
  input  logic                    err_clr,
  output logic                    busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                          r_state, w_state_n;
  logic [NCH-1:0]                  r_pending, w_pending_n;
  logic [NCH-1:0]                  w_grant_oh, w_in_svc, w_req, w_ovr_set;
  logic [2:0]                      r_rr_ptr, r_ch, w_pick_idx, w_ch_inc;
  logic                            w_pick_vld, w_lf_start, w_timeout;
  logic [CNT_W-1:0]                r_cnt;
  logic signed [WORD_W-1:0]        r_carr, r_code, w_carr_clamped;
  logic [NCH-1:0][WORD_W-1:0]      r_carr_off, r_code_off;
  logic [NCH-1:0]                  r_upd, r_ovr;
  logic                            r_tmo;

  gps_rr_pick #(.NCH(NCH)) u_pick (
    .i_pending (r_pending),
    .i_rr_ptr  (r_rr_ptr),
    .o_vld     (w_pick_vld),
    .o_idx     (w_pick_idx)
  );

  assign w_timeout = (r_state == WAIT) && !lf.lf_done && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_ch_inc  = (r_ch == 3'(NCH - 1)) ? 3'd0 : r_ch + 3'd1;
  assign w_req     = dump_req & ch_en;
  assign w_carr_clamped = WORD_W'(clamp_s($signed({{(CLAMP_W-WORD_W){r_carr[WORD_W-1]}}, r_carr}),
                                          $signed({{(CLAMP_W-WORD_W){1'b0}}, CARR_LIM})));

  // State register.
  always_ff @(posedge mclk) begin
    if (mclr) r_state <= IDLE;
    else      r_state <= w_state_n;
  end

  // Next-state decode and engine start strobe.
  always_comb begin
    w_state_n  = r_state;
    w_lf_start = 1'b0;
    case (r_state)
      IDLE:    if (|r_pending) w_state_n = GRANT;
      GRANT: begin
        w_lf_start = w_pick_vld;
        w_state_n  = w_pick_vld ? WAIT : IDLE;
      end
      WAIT: begin
        if (lf.lf_done)     w_state_n = WRITE;
        else if (w_timeout) w_state_n = IDLE;
      end
      WRITE:   w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Per-channel grant and in-service decode for pending/overrun bookkeeping.
  always_comb begin
    w_grant_oh = '0;
    w_in_svc   = '0;
    for (int i = 0; i < NCH; i++) begin
      w_grant_oh[i] = w_lf_start && (w_pick_idx == 3'(i));
      w_in_svc[i]   = ((r_state == WAIT) || (r_state == WRITE)) && (r_ch == 3'(i));
    end
  end

  // A same-cycle request survives its own grant; a request while in service is dropped.
  assign w_pending_n = ((r_pending & ~w_grant_oh) | (w_req & ~w_in_svc)) & ch_en;
  assign w_ovr_set   = w_req & (r_pending | w_in_svc);

  // Scheduler control: pending, pointer, job channel, timeout counter, sticky flags.
  always_ff @(posedge mclk) begin
    if (mclr) begin
      r_pending <= '0;
      r_rr_ptr  <= 3'd0;
      r_ch      <= 3'd0;
      r_cnt     <= '0;
      r_ovr     <= '0;
      r_tmo     <= 1'b0;
    end else begin
      r_pending <= w_pending_n;
      if (w_lf_start) r_ch <= w_pick_idx;
      if (r_state == GRANT)     r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      if (w_timeout || (r_state == WRITE)) r_rr_ptr <= w_ch_inc;
      r_ovr <= err_clr ? '0   : (r_ovr | w_ovr_set);
      r_tmo <= err_clr ? 1'b0 : (r_tmo | w_timeout);
    end
  end

  // Capture the engine result; only consumed in WRITE, so no reset needed.
  always_ff @(posedge mclk) begin
    if ((r_state == WAIT) && lf.lf_done) begin
      r_carr <= $signed(lf.lf_carr);
      r_code <= $signed(lf.lf_code);
    end
  end

  // Offset holding registers and update strobe; a channel disabled mid-job is not written.
  always_ff @(posedge mclk) begin
    if (mclr) begin
      r_carr_off <= '0;
      r_code_off <= '0;
      r_upd      <= '0;
    end else begin
      r_upd <= '0;
      if ((r_state == WRITE) && ch_en[r_ch]) begin
        r_carr_off[r_ch] <= w_carr_clamped;
        r_code_off[r_ch] <= r_code;
        r_upd[r_ch]      <= 1'b1;
      end
    end
  end

  assign lf.lf_start  = w_lf_start;
  assign lf.lf_ch     = (r_state == GRANT) ? w_pick_idx : r_ch;
  assign carr_off     = r_carr_off;
  assign code_off     = r_code_off;
  assign upd_pulse    = r_upd;
  assign overrun      = r_ovr;
  assign timeout_err  = r_tmo;
  assign busy         = (r_state != IDLE);

endmodule
